// File: rtl/tensor_core_stream_controller.sv
// Streaming front end for small_tensor_core: assembles two 3x3 operands from a byte
// stream, runs one core operation for a fixed window and streams the 3x3 result out.
module tensor_core_stream_controller #(
    parameter int unsigned COMPUTE_CYCLES = 12
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic signed [7:0] in_data,
    input  logic        [2:0] in_opcode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic signed [7:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              should_start_tensor_core,
    output logic        [2:0] matrix_operation_select,
    output logic signed [7:0] tensor_core_input1 [3][3],
    output logic signed [7:0] tensor_core_input2 [3][3],
    input  logic signed [7:0] tensor_core_output [3][3]
);

    localparam int unsigned CW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic        [2:0] op_reg;
    logic        [4:0] beat_idx;
    logic        [4:0] last_idx;
    logic     [CW-1:0] wait_cnt;
    logic        [3:0] out_idx;
    logic signed [7:0] result [9];
    logic        [3:0] elem;
    logic        [1:0] row;
    logic        [1:0] col;
    logic              in_fire;
    logic              out_fire;
    logic              op_supported;

    assign in_fire      = in_valid && in_ready;
    assign out_fire     = out_valid && out_ready;
    assign op_supported = (op_reg <= 3'd2);
    assign last_idx     = (op_reg == 3'b010) ? 5'd8 : 5'd17;

    // Beats 0..8 fill A and 9..17 fill B, both row-major.
    always_comb begin
        elem = (beat_idx < 5'd9) ? beat_idx[3:0] : 4'(beat_idx - 5'd9);
        row  = 2'(elem / 4'd3);
        col  = 2'(elem % 4'd3);
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (in_fire) state_next = S_LOAD;
            S_LOAD:    if (in_fire && (beat_idx == last_idx)) state_next = S_START;
            S_START:   state_next = S_WAIT;
            S_WAIT:    if (wait_cnt == CW'(COMPUTE_CYCLES - 1)) state_next = S_CAPTURE;
            S_CAPTURE: state_next = S_DRAIN;
            S_DRAIN:   if (out_fire && out_last) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready                 = (state == S_IDLE) || (state == S_LOAD);
        busy                     = (state != S_IDLE);
        should_start_tensor_core = (state == S_START) && op_supported;
        out_valid                = (state == S_DRAIN);
        out_last                 = (state == S_DRAIN) && (out_idx == 4'd8);
        out_data                 = result[out_idx];
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            op_reg                  <= '0;
            beat_idx                <= '0;
            wait_cnt                <= '0;
            out_idx                 <= '0;
            matrix_operation_select <= '0;
            for (int unsigned r = 0; r < 3; r++) begin
                for (int unsigned c = 0; c < 3; c++) begin
                    tensor_core_input1[r][c] <= '0;
                    tensor_core_input2[r][c] <= '0;
                    result[r*3+c]            <= '0;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        op_reg <= in_opcode;
                        for (int unsigned r = 0; r < 3; r++) begin
                            for (int unsigned c = 0; c < 3; c++) begin
                                tensor_core_input1[r][c] <= '0;
                                tensor_core_input2[r][c] <= '0;
                            end
                        end
                        tensor_core_input1[0][0] <= in_data;
                        beat_idx <= 5'd1;
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        if (beat_idx < 5'd9) begin
                            tensor_core_input1[row][col] <= in_data;
                        end else begin
                            tensor_core_input2[row][col] <= in_data;
                        end
                        if (beat_idx == last_idx) begin
                            beat_idx                <= '0;
                            matrix_operation_select <= op_reg;
                        end else begin
                            beat_idx <= beat_idx + 5'd1;
                        end
                    end
                end
                S_START: wait_cnt <= '0;
                S_WAIT:  wait_cnt <= wait_cnt + CW'(1);
                S_CAPTURE: begin
                    // Unsupported opcodes never pulse the core, so their result is forced to zero.
                    for (int unsigned r = 0; r < 3; r++) begin
                        for (int unsigned c = 0; c < 3; c++) begin
                            result[r*3+c] <= op_supported ? tensor_core_output[r][c] : 8'sd0;
                        end
                    end
                    out_idx <= '0;
                end
                S_DRAIN: begin
                    if (out_fire) begin
                        out_idx <= out_last ? 4'd0 : out_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tensor_core_stream_controller.sv
// Self-checking bench for tensor_core_stream_controller with a behavioural tensor core
// and a matrix-level reference model.
module tb_tensor_core_stream_controller;

    localparam int unsigned CC = 12;
    typedef logic [8:0][7:0] mat_t;

    logic              clock_in = 1'b0;
    logic              reset_in = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_data = '0;
    logic        [2:0] in_opcode = '0;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              out_last;
    logic              busy;
    logic              should_start;
    logic        [2:0] mos;
    logic signed [7:0] ti1 [3][3];
    logic signed [7:0] ti2 [3][3];
    logic signed [7:0] tco [3][3];

    int errors = 0;
    int checks = 0;

    tensor_core_stream_controller #(.COMPUTE_CYCLES(CC)) dut (
        .clock_in                (clock_in),
        .reset_in                (reset_in),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_data                 (in_data),
        .in_opcode               (in_opcode),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_data                (out_data),
        .out_last                (out_last),
        .busy                    (busy),
        .should_start_tensor_core(should_start),
        .matrix_operation_select (mos),
        .tensor_core_input1      (ti1),
        .tensor_core_input2      (ti2),
        .tensor_core_output      (tco)
    );

    always #5 clock_in = ~clock_in;

    // Matrix semantics of the core: 0 multiply, 1 add, 2 ReLU(A); others give junk.
    function automatic mat_t core_fn(input logic [2:0] op, input mat_t a, input mat_t b);
        mat_t r;
        int   s;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                case (op)
                    3'd0: begin
                        s = 0;
                        for (int k = 0; k < 3; k++) s += $signed(a[i*3+k]) * $signed(b[k*3+j]);
                        r[i*3+j] = s[7:0];
                    end
                    3'd1:    r[i*3+j] = a[i*3+j] + b[i*3+j];
                    3'd2:    r[i*3+j] = a[i*3+j][7] ? 8'd0 : a[i*3+j];
                    default: r[i*3+j] = 8'hA5;
                endcase
            end
        end
        return r;
    endfunction

    function automatic mat_t expected_out(input logic [2:0] op, input mat_t a, input mat_t b);
        return (op <= 3'd2) ? core_fn(op, a, b) : '0;
    endfunction

    mat_t p1, p2;
    mat_t core_res = {9{8'h5A}};
    logic       core_busy = 1'b0;
    logic [3:0] core_cnt = '0;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                p1[r*3+c] = ti1[r][c];
                p2[r*3+c] = ti2[r][c];
                tco[r][c] = core_res[r*3+c];
            end
        end
    end

    // Core model: output is junk until ~10 cycles after the start pulse.
    always @(posedge clock_in) begin
        if (reset_in) begin
            core_busy <= 1'b0;
        end else if (should_start) begin
            core_busy <= 1'b1;
            core_cnt  <= '0;
            core_res  <= {9{8'h5A}};
        end else if (core_busy) begin
            core_cnt <= core_cnt + 4'd1;
            if (core_cnt == 4'd9) begin
                core_busy <= 1'b0;
                core_res  <= core_fn(mos, p1, p2);
            end
        end
    end

    // Output-ready generator: 0 always 1, 1 pattern 1,0,0, 2 manual, 3 random.
    int   rdy_mode = 0;
    logic man_ready = 1'b0;
    logic auto_ready = 1'b1;
    int   rcnt = 0;
    assign out_ready = (rdy_mode == 2) ? man_ready : auto_ready;

    always @(posedge clock_in) begin
        #1;
        case (rdy_mode)
            1: begin
                auto_ready = (rcnt % 3 == 0);
                rcnt++;
            end
            3:       auto_ready = 1'($urandom_range(0, 1));
            default: auto_ready = 1'b1;
        endcase
    end

    // Monitor, sampled mid-cycle on the falling edge.
    int   clr_gen = 0, seen_gen = 0;
    int   cyc = 0, in_beats, first_in_cyc, last_in_cyc, starts, start_cyc, first_out_cyc;
    int   stall_viol, valid_cnt, d_cyc;
    logic gap_ok, prev_stall, prev_l;
    logic [7:0] prev_d;
    logic [7:0] outq[$];
    logic       lastq[$];
    mat_t snap_a, snap_b;
    logic [2:0] snap_op;

    always @(negedge clock_in) begin
        if (clr_gen != seen_gen) begin
            seen_gen = clr_gen;
            in_beats = 0; first_in_cyc = -1; last_in_cyc = -1;
            starts = 0; start_cyc = -1; first_out_cyc = -1;
            outq.delete(); lastq.delete();
            stall_viol = 0; valid_cnt = 0; d_cyc = -10; gap_ok = 1'b0; prev_stall = 1'b0;
            snap_a = '0; snap_b = '0; snap_op = '0;
        end
        cyc++;
        if (cyc == d_cyc + 1) gap_ok = !out_valid && in_ready;
        if (in_valid && in_ready) begin
            if (in_beats == 0) first_in_cyc = cyc;
            last_in_cyc = cyc;
            in_beats++;
        end
        if (should_start) begin
            starts++; start_cyc = cyc; snap_a = p1; snap_b = p2; snap_op = mos;
        end
        if (out_valid) begin
            valid_cnt++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (prev_stall && (out_data !== prev_d || out_last !== prev_l)) stall_viol++;
            if (out_ready) begin
                outq.push_back(out_data);
                lastq.push_back(out_last);
                if (out_last) d_cyc = cyc;
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_d = out_data;
        prev_l = out_last;
    end

    mat_t stim_a, stim_b;
    logic tmo;

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic clear_mon();
        clr_gen++;
        tmo = 1'b0;
    endtask

    task automatic send_beats(input int op, input int nbeats, input int gap_pct, input int extra);
        logic acc;
        int   t;
        for (int i = 0; i < nbeats; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                tick();
            end
            in_valid  = 1'b1;
            in_data   = (i < 9) ? stim_a[i] : stim_b[i-9];
            in_opcode = (i == 0) ? 3'(op) : 3'($urandom);
            t = 0;
            do begin
                acc = in_ready;
                tick();
                t++;
            end while (!acc && t < 200);
            if (!acc) begin
                tmo = 1'b1;
                break;
            end
        end
        for (int i = 0; i < extra; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int n);
        int t;
        t = 0;
        while (outq.size() < n && t < 500) begin
            tick();
            t++;
        end
        if (outq.size() < n) tmo = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b want 0", out_last); end
        checks++; if (should_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", should_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (mos !== 3'd0) begin errors++; $display("FAIL reset_op_select: got %0d want 0", mos); end
        checks++; if (p1 !== '0 || p2 !== '0) begin errors++; $display("FAIL reset_operands: got %h/%h want 0", p1, p2); end
        checks++; if (out_data !== 8'sd0) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        reset_in = 1'b0;
        tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_multiply();
        for (int i = 0; i < 9; i++) begin
            stim_a[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
            stim_b[i] = 8'(i + 1);
        end
        rdy_mode = 0;
        clear_mon();
        send_beats(0, 18, 0, 0);
        wait_outputs(9);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL mul_timeout: got %b want 0", tmo); end
        checks++; if (starts != 1) begin errors++; $display("FAIL mul_starts: got %0d want 1", starts); end
        checks++; if (last_in_cyc - first_in_cyc != 17) begin errors++; $display("FAIL mul_back_to_back: got span %0d want 17", last_in_cyc - first_in_cyc); end
        checks++; if (start_cyc != last_in_cyc + 1) begin errors++; $display("FAIL mul_start_latency: got %0d want %0d", start_cyc, last_in_cyc + 1); end
        checks++; if (first_out_cyc != last_in_cyc + 3 + int'(CC)) begin errors++; $display("FAIL mul_out_latency: got %0d want %0d", first_out_cyc, last_in_cyc + 3 + int'(CC)); end
        checks++; if (snap_op !== 3'd0 || snap_a !== stim_a || snap_b !== stim_b) begin errors++; $display("FAIL mul_operands: got op %0d A %h B %h", snap_op, snap_a, snap_b); end
        for (int k = 0; k < 9; k++) begin
            checks++; if (k >= outq.size() || outq[k] !== 8'(k + 1) || lastq[k] !== (k == 8)) begin errors++; $display("FAIL mul_beat%0d: got %h last %b want %h last %b", k, (k < outq.size()) ? outq[k] : 8'hxx, (k < lastq.size()) ? lastq[k] : 1'bx, 8'(k + 1), k == 8); end
        end
        checks++; if (gap_ok !== 1'b1) begin errors++; $display("FAIL mul_gap_after_last: got %b want 1", gap_ok); end
    endtask

    task automatic test_add_wrap();
        for (int i = 0; i < 9; i++) begin
            stim_a[i] = 8'd100;
            stim_b[i] = 8'd50;
        end
        clear_mon();
        send_beats(1, 18, 0, 0);
        wait_outputs(9);
        checks++; if (tmo !== 1'b0 || starts != 1) begin errors++; $display("FAIL add_run: got timeout %b starts %0d want 0/1", tmo, starts); end
        for (int k = 0; k < 9; k++) begin
            checks++; if (k >= outq.size() || outq[k] !== 8'h96) begin errors++; $display("FAIL add_beat%0d: got %h want 96", k, (k < outq.size()) ? outq[k] : 8'hxx); end
        end
    endtask

    task automatic test_relu();
        logic [7:0] want;
        for (int i = 0; i < 9; i++) begin
            stim_a[i] = (i % 2 == 0) ? 8'(-(i + 1)) : 8'(i + 1);
            stim_b[i] = 8'($urandom);
        end
        clear_mon();
        send_beats(2, 9, 0, 3);
        wait_outputs(9);
        checks++; if (in_beats != 9) begin errors++; $display("FAIL relu_beats_accepted: got %0d want 9", in_beats); end
        checks++; if (starts != 1 || snap_op !== 3'd2) begin errors++; $display("FAIL relu_start: got %0d op %0d want 1 op 2", starts, snap_op); end
        checks++; if (snap_b !== '0) begin errors++; $display("FAIL relu_b_cleared: got %h want 0", snap_b); end
        for (int k = 0; k < 9; k++) begin
            want = (k % 2 == 0) ? 8'd0 : 8'(k + 1);
            checks++; if (k >= outq.size() || outq[k] !== want) begin errors++; $display("FAIL relu_beat%0d: got %h want %h", k, (k < outq.size()) ? outq[k] : 8'hxx, want); end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 9; i++) begin
            stim_a[i] = (i % 4 == 0) ? 8'd1 : 8'd0;
            stim_b[i] = 8'(i + 1);
        end
        rdy_mode = 1;
        clear_mon();
        send_beats(0, 18, 30, 0);
        wait_outputs(9);
        rdy_mode = 0;
        checks++; if (tmo !== 1'b0 || starts != 1) begin errors++; $display("FAIL bp_run: got timeout %b starts %0d want 0/1", tmo, starts); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_viol); end
        checks++; if (start_cyc != last_in_cyc + 1) begin errors++; $display("FAIL bp_start_latency: got %0d want %0d", start_cyc, last_in_cyc + 1); end
        checks++; if (first_out_cyc != last_in_cyc + 3 + int'(CC)) begin errors++; $display("FAIL bp_out_latency: got %0d want %0d", first_out_cyc, last_in_cyc + 3 + int'(CC)); end
        for (int k = 0; k < 9; k++) begin
            checks++; if (k >= outq.size() || outq[k] !== 8'(k + 1) || lastq[k] !== (k == 8)) begin errors++; $display("FAIL bp_beat%0d: got %h want %h", k, (k < outq.size()) ? outq[k] : 8'hxx, 8'(k + 1)); end
        end
    endtask

    task automatic test_reset_mid();
        mat_t exp;
        int   t;
        for (int i = 0; i < 9; i++) begin
            stim_a[i] = 8'($urandom);
            stim_b[i] = 8'($urandom);
        end
        clear_mon();
        send_beats(0, 5, 0, 0);
        reset_in = 1'b1;
        tick();
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || should_start !== 1'b0) begin errors++; $display("FAIL rst_load_outputs: got busy %b in_ready %b out_valid %b start %b want 0 1 0 0", busy, in_ready, out_valid, should_start); end
        checks++; if (p1 !== '0 || p2 !== '0) begin errors++; $display("FAIL rst_load_operands: got %h/%h want 0", p1, p2); end
        reset_in = 1'b0;
        repeat (40) tick();
        checks++; if (starts != 0 || valid_cnt != 0) begin errors++; $display("FAIL rst_load_quiet: got starts %0d valids %0d want 0 0", starts, valid_cnt); end

        rdy_mode  = 2;
        man_ready = 1'b0;
        clear_mon();
        send_beats(1, 18, 0, 0);
        t = 0;
        while (!out_valid && t < 300) begin tick(); t++; end
        man_ready = 1'b1;
        t = 0;
        while (outq.size() < 3 && t < 50) begin tick(); t++; end
        man_ready = 1'b0;
        checks++; if (outq.size() != 3) begin errors++; $display("FAIL rst_drain_beats_before: got %0d want 3", outq.size()); end
        reset_in = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || mos !== 3'd0) begin errors++; $display("FAIL rst_drain_outputs: got valid %b last %b busy %b op %0d want 0 0 0 0", out_valid, out_last, busy, mos); end
        reset_in = 1'b0;
        clear_mon();
        man_ready = 1'b1;
        repeat (40) tick();
        checks++; if (starts != 0 || valid_cnt != 0) begin errors++; $display("FAIL rst_drain_quiet: got starts %0d valids %0d want 0 0", starts, valid_cnt); end

        rdy_mode = 0;
        clear_mon();
        send_beats(1, 18, 0, 0);
        wait_outputs(9);
        exp = expected_out(3'd1, stim_a, stim_b);
        for (int k = 0; k < 9; k++) begin
            checks++; if (k >= outq.size() || outq[k] !== exp[k]) begin errors++; $display("FAIL rst_fresh_add_beat%0d: got %h want %h", k, (k < outq.size()) ? outq[k] : 8'hxx, exp[k]); end
        end
    endtask

    task automatic test_unsupported();
        for (int i = 0; i < 9; i++) begin
            stim_a[i] = 8'($urandom_range(1, 127));
            stim_b[i] = 8'($urandom_range(1, 127));
        end
        clear_mon();
        send_beats(5, 18, 0, 0);
        wait_outputs(9);
        checks++; if (tmo !== 1'b0 || starts != 0) begin errors++; $display("FAIL unsup_start: got timeout %b starts %0d want 0 0", tmo, starts); end
        checks++; if (mos !== 3'b101) begin errors++; $display("FAIL unsup_op_select: got %0d want 5", mos); end
        for (int k = 0; k < 9; k++) begin
            checks++; if (k >= outq.size() || outq[k] !== 8'd0) begin errors++; $display("FAIL unsup_beat%0d: got %h want 00", k, (k < outq.size()) ? outq[k] : 8'hxx); end
        end
    endtask

    task automatic test_random();
        mat_t       exp;
        logic [2:0] op;
        rdy_mode = 3;
        for (int t = 0; t < 6; t++) begin
            op = 3'($urandom_range(0, 7));
            for (int i = 0; i < 9; i++) begin
                stim_a[i] = 8'($urandom);
                stim_b[i] = 8'($urandom);
            end
            clear_mon();
            send_beats(int'(op), (op == 3'd2) ? 9 : 18, 25, 0);
            wait_outputs(9);
            exp = expected_out(op, stim_a, stim_b);
            checks++; if (tmo !== 1'b0 || starts != ((op <= 3'd2) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_start: op %0d got timeout %b starts %0d", t, op, tmo, starts); end
            checks++; if (stall_viol != 0) begin errors++; $display("FAIL rand%0d_stall_stable: got %0d want 0", t, stall_viol); end
            for (int k = 0; k < 9; k++) begin
                checks++; if (k >= outq.size() || outq[k] !== exp[k] || lastq[k] !== (k == 8)) begin errors++; $display("FAIL rand%0d_beat%0d: op %0d got %h want %h", t, k, op, (k < outq.size()) ? outq[k] : 8'hxx, exp[k]); end
            end
        end
        rdy_mode = 0;
    endtask

    initial begin
        tick();
        tick();
        test_reset();
        test_multiply();
        test_add_wrap();
        test_relu();
        test_backpressure();
        test_reset_mid();
        test_unsupported();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
